uart_rx: RTL and testbench

Byte-oriented UART receiver with a receive FIFO, used as the far end of the SoC's serial transmit line. It deserialises 8N1 frames from a single serial input, buffers completed bytes in a show-ahead FIFO, and flags framing and overrun errors. It serves in simulation as the capture end of the SoC `TXD` output. It is also the receive half of the SoC UART peripheral, behind its bus wrapper.

---
 rtl/uart_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a show-ahead receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose the parity_err port.
module uart_rx #(
    parameter int unsigned BAUD_DIV   = 217,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       RXD,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       fifo_full,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0] CntFull = 16'(BAUD_DIV);
    localparam logic [15:0] CntHalf = 16'(BAUD_DIV / 2);
    localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } state_e;

    state_e state_q, state_d;

    logic        sync_q, rxs_q, rxs_d_q;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        cnt_done;
    logic        par_bad;
    logic        push, pop, push_req;
    logic        set_fe, set_ov, set_pe;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q;
    assign par_bad    = ^{shift_q, par_q};
    assign parity_err = parity_err_q;
`else
    assign par_bad = 1'b0;
`endif

    assign cnt_done  = (cnt_q == 16'd1);
    assign rx_valid  = (count_q != '0);
    assign fifo_full = (count_q == DepthC);
    assign pop       = rd_en && rx_valid;
    // Storage is not reset, so mask the head while empty.
    assign rd_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q  <= 1'b1;
            rxs_q   <= 1'b1;
            rxs_d_q <= 1'b1;
        end else begin
            sync_q  <= RXD;
            rxs_q   <= sync_q;
            rxs_d_q <= rxs_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (!rxs_q && rxs_d_q) state_d = StStart;
            StStart:    if (cnt_done) state_d = rxs_q ? StIdle : StData;
            StData: begin
                if (cnt_done && idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity:   if (cnt_done) state_d = StStop;
`endif
            StStop:     if (cnt_done) state_d = rxs_q ? StIdle : StWaitHigh;
            StWaitHigh: if (rxs_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs: bit-timer, shift register and stop-bit decisions.
    always_comb begin
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        push_req = 1'b0;
        set_fe   = 1'b0;
        set_pe   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rxs_q && rxs_d_q) begin
                    cnt_d = CntHalf;
                    idx_d = 3'd0;
                end
            end
            StStart: begin
                cnt_d = cnt_done ? CntFull : cnt_q - 16'd1;
            end
            StData: begin
                cnt_d = cnt_done ? CntFull : cnt_q - 16'd1;
                if (cnt_done) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                cnt_d = cnt_done ? CntFull : cnt_q - 16'd1;
                if (cnt_done) par_d = rxs_q;
            end
`endif
            StStop: begin
                cnt_d = cnt_done ? CntFull : cnt_q - 16'd1;
                if (cnt_done) begin
                    set_fe   = !rxs_q;
                    set_pe   = par_bad;
                    push_req = rxs_q && !par_bad;
                end
            end
            default: ;
        endcase
    end

    // A popped full FIFO has room for the byte arriving in the same cycle.
    assign push   = push_req && (!fifo_full || pop);
    assign set_ov = push_req && fifo_full && !pop;

    // Receive datapath registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q   <= 16'd0;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (RST) begin
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err    <= set_fe | (frame_err & ~clr_err);
            overrun      <= set_ov | (overrun & ~clr_err);
`ifdef UART_RX_PARITY_EN
            parity_err_q <= set_pe | (parity_err_q & ~clr_err);
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_pe;
    assign unused_pe = set_pe;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

    localparam int BD    = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid, fifo_full, frame_err, overrun;
    logic       parity_err;

    int vectors = 0;
    int errors  = 0;

    // Reference model: byte queue and sticky flags.
    logic [7:0] q[$];
    logic       m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;

    uart_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .RST       (RST),
        .RXD       (RXD),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .fifo_full (fifo_full),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".rx_valid"},  32'(rx_valid),  32'(q.size() != 0));
        chk({pfx, ".fifo_full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
        chk({pfx, ".rd_data"},   32'(rd_data),   (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk({pfx, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({pfx, ".overrun"},   32'(overrun),   32'(m_ov));
`ifdef UART_RX_PARITY_EN
        chk({pfx, ".parity_err"}, 32'(parity_err), 32'(m_pe));
`endif
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) tick();
    endtask

    task automatic pop(input string pfx);
        chk({pfx, ".pop_valid"}, 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({pfx, ".pop_head"}, 32'(rd_data), 32'(q[0]));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        m_pe = 1'b0;
    endtask

    // One frame, cycle by cycle. stop_low > 0 holds the stop bit low that many bit times;
    // pop_at_stop raises rd_en exactly in the stop-sample cycle; rst_at >= 0 pulses RST there.
    task automatic send_frame(input logic [7:0] data, input bit par_flip, input int stop_low,
                              input bit pop_at_stop, input int rst_at);
        logic bits[$];
        int nb, total, stop_c;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back((^data) ^ par_flip);
`endif
        nb     = bits.size() + 1;
        // Edge seen 2 cycles after RXD falls, stop sampled BD/2 + (nb-1)*BD later.
        stop_c = (nb - 1) * BD + BD / 2 + 2;
        total  = (stop_low > 0) ? (nb - 1 + stop_low) * BD + BD : nb * BD;
        for (int c = 0; c < total; c++) begin
            if (c / BD < nb - 1) RXD = bits[c / BD];
            else if (stop_low > 0 && c < (nb - 1 + stop_low) * BD) RXD = 1'b0;
            else RXD = 1'b1;
            rd_en = pop_at_stop && (c == stop_c);
            if (c == rst_at) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                RXD = 1'b1;
                q = {};
                m_fe = 1'b0;
                m_ov = 1'b0;
                m_pe = 1'b0;
                return;
            end
            tick();
        end
        rd_en = 1'b0;
        if (pop_at_stop && q.size() != 0) void'(q.pop_front());
        if (stop_low > 0) m_fe = 1'b1;
        if (par_flip) m_pe = 1'b1;
        if (stop_low == 0 && !par_flip) begin
            if (q.size() < DEPTH) q.push_back(data);
            else m_ov = 1'b1;
        end
    endtask

    initial begin
        repeat (3) tick();
        RST = 1'b0;
        check_all("reset");

        // Back-to-back frames.
        send_frame(8'h55, 0, 0, 0, -1);
        send_frame(8'hA3, 0, 0, 0, -1);
        check_all("b2b");
        pop("b2b0");
        pop("b2b1");
        check_all("b2b_empty");

        // Short low glitch is ignored.
        RXD = 1'b0;
        repeat (4) tick();
        idle(200);
        check_all("glitch");

        // Break: one framing error, no byte, then recovery.
        send_frame(8'h3C, 0, 20, 0, -1);
        idle(32);
        check_all("break");
        send_frame(8'h7E, 0, 0, 0, -1);
        check_all("after_break");
        clear_errors();
        check_all("clr_err");
        pop("p7e");

        // Fill, overrun, drain.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0, 0, 0, -1);
            if (i == 8) check_all("full8");
        end
        check_all("overrun9");
        for (int i = 0; i < 8; i++) pop("drain");
        check_all("drained");
        clear_errors();

        // Pop in the stop-sample cycle of a full FIFO accepts the byte.
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 0, 0, -1);
        check_all("refill");
        send_frame(8'h18, 0, 0, 1, -1);
        check_all("pop_at_stop");

        // Reset during data bit 4 with 3 bytes queued and a sticky error set.
        for (int i = 0; i < 5; i++) pop("trim");
        send_frame(8'h00, 0, 1, 0, -1);
        check_all("pre_reset");
        send_frame(8'hB6, 0, 0, 0, 5 * BD + BD / 2);
        check_all("mid_reset");
        idle(20);
        send_frame(8'hC5, 0, 0, 0, -1);
        check_all("post_reset");
        pop("pc5");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 0, 0, -1);
        check_all("par_bad");
        send_frame(8'h07, 0, 0, 0, -1);
        check_all("par_good");
        pop("p07");
        clear_errors();
`endif

        // Random frames, gaps, pops and occasional breaks.
        for (int n = 0; n < 40; n++) begin
            int np, gap, sl;
            np  = $urandom_range(0, 2);
            repeat (np) pop("rpop");
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            idle(gap);
            sl  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            send_frame(8'($urandom), 0, sl, 0, -1);
            check_all("rand");
            if ($urandom_range(0, 7) == 0) begin
                clear_errors();
                check_all("rand_clr");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
